ppm_rx_frame_buffer: RTL and testbench
======================================

# ppm_rx_frame_buffer

Receive-side frame buffer for the PPM link, sitting between the receiver's two-bit-symbol deserializer and the user interface. It captures the bytes of one frame between start-of-frame and end-of-frame indications. The transmitter sends payload bytes last-first, so this block presents them to the user in original order. A pop handshake drains the frame, then the block re-arms for the next frame.

## Interface
- DEPTH, 16: payload capacity in bytes; a power of two, and at most 16.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sof  input  1  one-cycle pulse from the demodulator: start-of-frame symbol detected.
- byte_valid  input  1  one-cycle pulse: byte_in carries a completed received byte.
- byte_in  input  8  received byte from the two-bit-symbol deserializer.
- eof  input  1  one-cycle pulse: end-of-frame detected.
- rd_en  input  1  user pops the current Dout byte; honoured only while dout_valid=1.
- Dout  output  8  registered output byte.
- dout_valid  output  1  Dout holds a valid, unpopped byte.
- frame_ready  output  1  a complete frame is held and is being drained.
- frame_len  output  5  number of bytes in the held frame, 1..DEPTH.
- frame_done  output  1  one-cycle pulse after the last byte is popped.
- overflow  output  1  sticky: more than DEPTH bytes arrived in the current frame.
- frame_err  output  1  one-cycle pulse: empty frame, or the frame was restarted by sof.

## Operation
- States (one-hot): IDLE, RECV, READY.
- Reset: state=IDLE and wr_count=0. All outputs are 0, including Dout=8'h00 and frame_len=0. Buffer contents are don't-care.
- IDLE
  - sof: go to RECV, wr_count<=0, overflow<=0.
  - byte_valid and eof are ignored.
- RECV, byte_valid:
  - If wr_count<DEPTH: buf[wr_count]<=byte_in and wr_count increments.
  - Otherwise the byte is discarded and overflow<=1.
- RECV, eof. Let n be wr_count plus 1 if a same-cycle byte_valid is accepted.
  - n==0: pulse frame_err and return to IDLE.
  - n>0: go to READY. frame_len<=n, rd_ptr<=n-1.
  - Dout<=buf[n-1], or byte_in when the same-cycle byte is the one written at n-1.
  - dout_valid<=1, frame_ready<=1.
- RECV, sof without eof: restart. wr_count<=0, overflow<=0, pulse frame_err, stay in RECV.
  - A byte_valid in the same cycle is discarded.
- RECV, sof and eof in the same cycle: eof takes priority and sof is ignored.
- READY, rd_en with dout_valid=1:
  - rd_ptr>0: rd_ptr decrements and Dout<=buf[rd_ptr-1].
  - rd_ptr==0: dout_valid<=0, frame_ready<=0, frame_len<=0, pulse frame_done, go to IDLE.
- READY: sof, byte_valid and eof are ignored. A frame arriving while one is held is lost.
- Output order: the first byte received is presented last, restoring the sender's original byte order.
- overflow stays set through READY and clears on the next accepted sof.
- Width rules:
  - wr_count is 5 bits (0..DEPTH); rd_ptr is 4 bits.
  - frame_len equals wr_count at eof, clamped to DEPTH when overflowed.

## Timing
- Latency from eof to valid data:
  - eof sampled at edge k: frame_ready, dout_valid, Dout and frame_len are all valid after edge k.
  - Latency is 1 cycle.
- Pop handshake: rd_en sampled at edge k with dout_valid=1 puts the next byte on Dout after edge k.
  - Back-to-back rd_en drains one byte per cycle.
- A frame of n bytes popped continuously: frame_done pulses on the cycle after the n-th pop.
  - sof is accepted from that same cycle onward, since the state is IDLE.
- rd_en while dout_valid=0 has no effect.
- Every output stays stable between qualifying events.
- Reset asserted mid-frame or mid-drain: all outputs drop to 0 immediately, asynchronously. The frame is discarded.

## Test plan
- Basic frame: sof, then bytes 0x44, 0x33, 0x22, 0x11, then eof. Pop continuously.
  - Required: frame_len=4; Dout sequence 0x11, 0x22, 0x33, 0x44.
  - Required: frame_done pulses once, one cycle after the 4th pop.
- Last byte with eof: sof, bytes 0xA0, then 0xB1 in the same cycle as eof.
  - Required: frame_len=2; first Dout=0xB1 one cycle after eof, then 0xA0.
- Overflow: sof, then 18 bytes 0x00..0x11, then eof.
  - Required: overflow=1, frame_len=16; Dout runs 0x0F down to 0x00; bytes 0x10 and 0x11 are dropped.
- Empty frame and restart:
  - sof then eof with no bytes: frame_err pulse, state back to IDLE, frame_ready stays 0.
  - sof, byte 0x55, sof, byte 0x66, eof: frame_err pulse; frame_len=1, Dout=0x66.
- Stalled read and ignored input: a 3-byte frame with rd_en held low for 10 cycles.
  - Required: Dout stays stable throughout.
  - Inject sof and byte_valid during READY: no change to the frame, frame_len or Dout.
- Reset mid-drain: assert rst after 1 of 3 pops.
  - Required: all outputs 0 at once; a subsequent 1-byte frame with 0x7E drains correctly.

Source files
------------

// File: rtl/ppm_rx_frame_buffer.sv
// ppm_rx_frame_buffer
// Captures the payload bytes of one PPM frame between sof and eof. The sender
// transmits payload last-first, so the held frame is drained from the most
// recently written byte back to the first one, restoring the original order.
// After the final pop the block returns to IDLE and waits for the next sof.

module ppm_rx_frame_buffer #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sof,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  input  logic       eof,
  input  logic       rd_en,
  output logic [7:0] Dout,
  output logic       dout_valid,
  output logic       frame_ready,
  output logic [4:0] frame_len,
  output logic       frame_done,
  output logic       overflow,
  output logic       frame_err
);

  localparam logic [4:0] DEPTH_W = 5'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    RECV  = 3'b010,
    READY = 3'b100
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] wr_count, wr_count_nxt;
  logic [3:0] rd_ptr, rd_ptr_nxt;
  logic [7:0] dout_nxt;
  logic       dout_valid_nxt;
  logic       frame_ready_nxt;
  logic [4:0] frame_len_nxt;
  logic       frame_done_nxt;
  logic       overflow_nxt;
  logic       frame_err_nxt;

  // Sized for the largest legal DEPTH; entries above DEPTH-1 are never written.
  logic [7:0] frame_mem [0:15];

  logic       restart;
  logic       byte_ok;
  logic       byte_drop;
  logic [4:0] n_len;
  logic [4:0] n_len_m1;
  logic [3:0] last_idx;
  logic [3:0] rd_ptr_m1;

  // A sof without eof while receiving restarts the frame and swallows any
  // same-cycle byte; eof wins over sof when both arrive together.
  assign restart   = (state == RECV) && sof && !eof;
  assign byte_ok   = (state == RECV) && byte_valid && !restart && (wr_count < DEPTH_W);
  assign byte_drop = (state == RECV) && byte_valid && !restart && (wr_count >= DEPTH_W);
  assign n_len     = wr_count + {4'd0, byte_ok};
  assign n_len_m1  = n_len - 5'd1;
  assign last_idx  = n_len_m1[3:0];
  assign rd_ptr_m1 = rd_ptr - 4'd1;

  // Payload storage; contents need no reset since wr_count gates every read.
  always_ff @(posedge clk) begin
    if (byte_ok) begin
      frame_mem[wr_count[3:0]] <= byte_in;
    end
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_count    <= 5'd0;
      rd_ptr      <= 4'd0;
      Dout        <= 8'h00;
      dout_valid  <= 1'b0;
      frame_ready <= 1'b0;
      frame_len   <= 5'd0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_count    <= wr_count_nxt;
      rd_ptr      <= rd_ptr_nxt;
      Dout        <= dout_nxt;
      dout_valid  <= dout_valid_nxt;
      frame_ready <= frame_ready_nxt;
      frame_len   <= frame_len_nxt;
      frame_done  <= frame_done_nxt;
      overflow    <= overflow_nxt;
      frame_err   <= frame_err_nxt;
    end
  end

  // Next-state and output decode; pulses default low, everything else holds.
  always_comb begin
    state_nxt       = state;
    wr_count_nxt    = wr_count;
    rd_ptr_nxt      = rd_ptr;
    dout_nxt        = Dout;
    dout_valid_nxt  = dout_valid;
    frame_ready_nxt = frame_ready;
    frame_len_nxt   = frame_len;
    frame_done_nxt  = 1'b0;
    overflow_nxt    = overflow;
    frame_err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (sof) begin
          state_nxt    = RECV;
          wr_count_nxt = 5'd0;
          overflow_nxt = 1'b0;
        end
      end

      RECV: begin
        if (byte_ok) begin
          wr_count_nxt = wr_count + 5'd1;
        end
        if (byte_drop) begin
          overflow_nxt = 1'b1;
        end
        if (eof) begin
          if (n_len == 5'd0) begin
            frame_err_nxt = 1'b1;
            state_nxt     = IDLE;
          end else begin
            state_nxt       = READY;
            frame_len_nxt   = n_len;
            rd_ptr_nxt      = last_idx;
            dout_nxt        = byte_ok ? byte_in : frame_mem[last_idx];
            dout_valid_nxt  = 1'b1;
            frame_ready_nxt = 1'b1;
          end
        end else if (sof) begin
          wr_count_nxt  = 5'd0;
          overflow_nxt  = 1'b0;
          frame_err_nxt = 1'b1;
        end
      end

      READY: begin
        if (rd_en && dout_valid) begin
          if (rd_ptr != 4'd0) begin
            rd_ptr_nxt = rd_ptr_m1;
            dout_nxt   = frame_mem[rd_ptr_m1];
          end else begin
            dout_valid_nxt  = 1'b0;
            frame_ready_nxt = 1'b0;
            frame_len_nxt   = 5'd0;
            frame_done_nxt  = 1'b1;
            state_nxt       = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ppm_rx_frame_buffer.sv
// tb_ppm_rx_frame_buffer
// Table-driven bench: each record holds one cycle of inputs and the outputs
// expected just after the following rising edge. The asynchronous reset
// cases are hand-written around the tables.

module tb_ppm_rx_frame_buffer;

  logic       clk;
  logic       rst;
  logic       sof;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       eof;
  logic       rd_en;
  logic [7:0] Dout;
  logic       dout_valid;
  logic       frame_ready;
  logic [4:0] frame_len;
  logic       frame_done;
  logic       overflow;
  logic       frame_err;

  typedef struct {
    string      name;
    logic       sof;
    logic       bv;
    logic [7:0] din;
    logic       eof;
    logic       rd;
    logic [7:0] e_dout;
    logic       e_dv;
    logic       e_fr;
    logic [4:0] e_len;
    logic       e_done;
    logic       e_ovf;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  ppm_rx_frame_buffer #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sof        (sof),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .eof        (eof),
    .rd_en      (rd_en),
    .Dout       (Dout),
    .dout_valid (dout_valid),
    .frame_ready(frame_ready),
    .frame_len  (frame_len),
    .frame_done (frame_done),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void add(input string name,
                              input logic s, input logic bv, input logic [7:0] din,
                              input logic e, input logic rd,
                              input logic [7:0] e_dout, input logic e_dv, input logic e_fr,
                              input logic [4:0] e_len, input logic e_done,
                              input logic e_ovf, input logic e_err);
    vec_t v;
    v.name = name; v.sof = s; v.bv = bv; v.din = din; v.eof = e; v.rd = rd;
    v.e_dout = e_dout; v.e_dv = e_dv; v.e_fr = e_fr; v.e_len = e_len;
    v.e_done = e_done; v.e_ovf = e_ovf; v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input vec_t v);
    logic [17:0] got, exp;
    got = {Dout, dout_valid, frame_ready, frame_len, frame_done, overflow, frame_err};
    exp = {v.e_dout, v.e_dv, v.e_fr, v.e_len, v.e_done, v.e_ovf, v.e_err};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got Dout=%h dv=%b fr=%b len=%0d done=%b ovf=%b err=%b, expected Dout=%h dv=%b fr=%b len=%0d done=%b ovf=%b err=%b",
               v.name, Dout, dout_valid, frame_ready, frame_len, frame_done, overflow, frame_err,
               v.e_dout, v.e_dv, v.e_fr, v.e_len, v.e_done, v.e_ovf, v.e_err);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sof        = v.sof;
    byte_valid = v.bv;
    byte_in    = v.din;
    eof        = v.eof;
    rd_en      = v.rd;
    @(posedge clk);
    #1;
    sof        = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    eof        = 1'b0;
    rd_en      = 1'b0;
    checkOutput(v);
  endtask

  task automatic checkZero(input string name);
    vec_t z;
    z.name = name; z.sof = 0; z.bv = 0; z.din = 0; z.eof = 0; z.rd = 0;
    z.e_dout = 8'h00; z.e_dv = 0; z.e_fr = 0; z.e_len = 5'd0;
    z.e_done = 0; z.e_ovf = 0; z.e_err = 0;
    checkOutput(z);
  endtask

  initial begin
    rst = 1'b1; sof = 0; byte_valid = 0; byte_in = 0; eof = 0; rd_en = 0;
    repeat (2) @(posedge clk);
    #1;
    checkZero("reset_state");
    rst = 1'b0;

    // Basic 4-byte frame, drained continuously
    add("b_sof",  1,0,8'h00,0,0, 8'h00,0,0,5'd0,0,0,0);
    add("b_d44",  0,1,8'h44,0,0, 8'h00,0,0,5'd0,0,0,0);
    add("b_d33",  0,1,8'h33,0,0, 8'h00,0,0,5'd0,0,0,0);
    add("b_d22",  0,1,8'h22,0,0, 8'h00,0,0,5'd0,0,0,0);
    add("b_d11",  0,1,8'h11,0,0, 8'h00,0,0,5'd0,0,0,0);
    add("b_eof",  0,0,8'h00,1,0, 8'h11,1,1,5'd4,0,0,0);
    add("b_pop1", 0,0,8'h00,0,1, 8'h22,1,1,5'd4,0,0,0);
    add("b_pop2", 0,0,8'h00,0,1, 8'h33,1,1,5'd4,0,0,0);
    add("b_pop3", 0,0,8'h00,0,1, 8'h44,1,1,5'd4,0,0,0);
    add("b_pop4", 0,0,8'h00,0,1, 8'h44,0,0,5'd0,1,0,0);
    add("b_idle", 0,0,8'h00,0,0, 8'h44,0,0,5'd0,0,0,0);

    // Last byte arrives with eof
    add("l_sof",  1,0,8'h00,0,0, 8'h44,0,0,5'd0,0,0,0);
    add("l_dA0",  0,1,8'hA0,0,0, 8'h44,0,0,5'd0,0,0,0);
    add("l_eof",  0,1,8'hB1,1,0, 8'hB1,1,1,5'd2,0,0,0);
    add("l_pop1", 0,0,8'h00,0,1, 8'hA0,1,1,5'd2,0,0,0);
    add("l_pop2", 0,0,8'h00,0,1, 8'hA0,0,0,5'd0,1,0,0);

    // Overflow: 18 bytes into a 16-byte buffer
    add("o_sof",  1,0,8'h00,0,0, 8'hA0,0,0,5'd0,0,0,0);
    for (int i = 0; i < 18; i++)
      add($sformatf("o_byte%0d", i), 0,1,8'(i),0,0, 8'hA0,0,0,5'd0,0,(i >= 16),0);
    add("o_eof",  0,0,8'h00,1,0, 8'h0F,1,1,5'd16,0,1,0);
    for (int k = 1; k < 16; k++)
      add($sformatf("o_pop%0d", k), 0,0,8'h00,0,1, 8'(15 - k),1,1,5'd16,0,1,0);
    add("o_pop16", 0,0,8'h00,0,1, 8'h00,0,0,5'd0,1,1,0);
    add("o_idle",  0,0,8'h00,0,0, 8'h00,0,0,5'd0,0,1,0);

    // Empty frame, then inputs ignored in IDLE
    add("e_sof",  1,0,8'h00,0,0, 8'h00,0,0,5'd0,0,0,0);
    add("e_eof",  0,0,8'h00,1,0, 8'h00,0,0,5'd0,0,0,1);
    add("e_ign",  0,1,8'h99,1,1, 8'h00,0,0,5'd0,0,0,0);

    // Restart by sof, with a same-cycle byte discarded
    add("r_sof",  1,0,8'h00,0,0, 8'h00,0,0,5'd0,0,0,0);
    add("r_d55",  0,1,8'h55,0,0, 8'h00,0,0,5'd0,0,0,0);
    add("r_rst",  1,1,8'h77,0,0, 8'h00,0,0,5'd0,0,0,1);
    add("r_d66",  0,1,8'h66,0,0, 8'h00,0,0,5'd0,0,0,0);
    add("r_eof",  0,0,8'h00,1,0, 8'h66,1,1,5'd1,0,0,0);
    add("r_pop",  0,0,8'h00,0,1, 8'h66,0,0,5'd0,1,0,0);

    // Stalled read with ignored traffic during READY
    add("s_sof",  1,0,8'h00,0,0, 8'h66,0,0,5'd0,0,0,0);
    add("s_d01",  0,1,8'h01,0,0, 8'h66,0,0,5'd0,0,0,0);
    add("s_d02",  0,1,8'h02,0,0, 8'h66,0,0,5'd0,0,0,0);
    add("s_d03",  0,1,8'h03,0,0, 8'h66,0,0,5'd0,0,0,0);
    add("s_eof",  0,0,8'h00,1,0, 8'h03,1,1,5'd3,0,0,0);
    for (int i = 0; i < 10; i++)
      add($sformatf("s_stall%0d", i), 0,0,8'h00,0,0, 8'h03,1,1,5'd3,0,0,0);
    add("s_sofign", 1,0,8'h00,0,0, 8'h03,1,1,5'd3,0,0,0);
    add("s_bvign",  0,1,8'hEE,0,0, 8'h03,1,1,5'd3,0,0,0);
    add("s_eofign", 0,0,8'h00,1,0, 8'h03,1,1,5'd3,0,0,0);
    add("s_pop1",   0,0,8'h00,0,1, 8'h02,1,1,5'd3,0,0,0);
    add("s_pop2",   0,0,8'h00,0,1, 8'h01,1,1,5'd3,0,0,0);
    add("s_pop3",   0,0,8'h00,0,1, 8'h01,0,0,5'd0,1,0,0);

    // Frame set up for the mid-drain reset
    add("x_sof",  1,0,8'h00,0,0, 8'h01,0,0,5'd0,0,0,0);
    add("x_d0A",  0,1,8'h0A,0,0, 8'h01,0,0,5'd0,0,0,0);
    add("x_d0B",  0,1,8'h0B,0,0, 8'h01,0,0,5'd0,0,0,0);
    add("x_d0C",  0,1,8'h0C,0,0, 8'h01,0,0,5'd0,0,0,0);
    add("x_eof",  0,0,8'h00,1,0, 8'h0C,1,1,5'd3,0,0,0);
    add("x_pop1", 0,0,8'h00,0,1, 8'h0B,1,1,5'd3,0,0,0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Asynchronous reset mid-drain: outputs must clear before the next edge
    #3;
    rst = 1'b1;
    #1;
    checkZero("rst_middrain");
    @(posedge clk);
    #1;
    rst = 1'b0;

    vecs.delete();
    add("z_sof",  1,0,8'h00,0,0, 8'h00,0,0,5'd0,0,0,0);
    add("z_d7E",  0,1,8'h7E,0,0, 8'h00,0,0,5'd0,0,0,0);
    add("z_eof",  0,0,8'h00,1,0, 8'h7E,1,1,5'd1,0,0,0);
    add("z_pop",  0,0,8'h00,0,1, 8'h7E,0,0,5'd0,1,0,0);
    add("z_idle", 0,0,8'h00,0,0, 8'h7E,0,0,5'd0,0,0,0);
    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
